dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Load/store sequencer between the core's memory stage and the data memory. Accepts one byte/half/word request per valid/ready handshake and converts it into one or more registered single-cycle data-memory accesses using the memory's MemWrite/SizeLoad encoding. Performs load byte-lane extraction and sign/zero extension itself. Optionally splits misaligned accesses into multiple memory beats.

## Interface
- `ADDR_W`, default 32: request/memory address width.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept; a request is accepted on a cycle with `req_valid & req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned` in 1: zero-extend byte/half loads. Ignored for word loads and all stores.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: request rejected, no memory write performed; valid with `rsp_valid`.
- `mem_write` out 2: 00 none, 01 word store, 10 half store, 11 byte store.
- `mem_size_load` out 3: always 000 (word read).
- `mem_addr` out ADDR_W: memory byte address.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: combinational memory read data.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE
  - `req_ready`=1.
  - On accept, latch addr/wdata/size/we/unsigned and compute the beat count.
  - Illegal size or a disallowed misaligned access goes to RESP with error set. Otherwise go to BUSY with beat=0.
- BUSY
  - `req_ready`=0. All `mem_*` outputs come from registers; there is no combinational path from `req_*` to `mem_*`.
  - Load beat k: `mem_addr`={addr[ADDR_W-1:2],2'b00}+4k, `mem_write`=00. `mem_rdata` is captured into buffer word k at the clock edge.
  - Aligned store (one beat): `mem_write` = 01/10/11 for word/half/byte. `mem_addr`=addr. `mem_wdata` = wdata with the byte/half replicated into its lane.
  - Misaligned store beat k: `mem_write`=11, `mem_addr`=addr+k, `mem_wdata` = byte k of wdata in the byte lane selected by (addr+k)[1:0].
  - After the last beat, go to RESP.
- RESP
  - `rsp_valid`=1 for exactly one cycle, then IDLE. No response backpressure.
- Misalignment
  - Half access with addr[0]=1, or word access with addr[1:0]≠0.
  - Misaligned load: 2 beats if the access crosses a word boundary (half at offset 3, word at offset 1–3); otherwise 1 beat.
  - Misaligned store: 2 byte beats for a half, 4 byte beats for a word.
  - Aligned access: 1 beat.
- Load assembly
  - Form the 64-bit value {buf1,buf0} and shift right by 8·addr[1:0].
  - Take the low 8/16/32 bits; sign- or zero-extend per `req_unsigned`.
- Address arithmetic is modulo 2^ADDR_W; wrap past the top of memory is not flagged.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `mem_write`=00, `mem_size_load`=000, `mem_addr`=0, `mem_wdata`=0.
- Outside BUSY, `mem_write`=00 and `mem_addr`/`mem_wdata` hold 0.
- Request accepted at edge 0:
  - Error: `rsp_valid` in cycle 1.
  - 1-beat access: BUSY in cycle 1, `rsp_valid` in cycle 2.
  - 2-beat access: `rsp_valid` in cycle 3.
  - 4-beat store: `rsp_valid` in cycle 5.
- Store data is committed at the end of each BUSY beat.
- Next request can be accepted in the cycle after RESP. `req_valid` asserted in RESP is held until IDLE.
- Reset mid-operation returns to IDLE immediately and issues no further beats. Already-written bytes of a split store remain written; no response is produced.

## Configuration
- `DMEM_LSU_MISALIGN_EN` defined: misaligned accesses are split as above.
- Not defined:
  - Any misaligned access produces `rsp_err`=1, `rsp_rdata`=0 in cycle 1 with no memory beat.
  - Beat counter and second buffer word are omitted.

## Test plan
- Reset with `req_valid`=1 → `req_ready`=1, `mem_write`=00, `rsp_valid`=0 for every reset cycle.
- Store word 0xDEADBEEF @0x10, then load word @0x10 → `mem_write`=01 in cycle 1; load `rsp_rdata`=0xDEADBEEF in cycle 2.
- Memory word @0x10 = 0x80FF7F01:
  - LB @0x12 → 0xFFFFFFFF.
  - LBU @0x13 → 0x00000080.
  - LH @0x12 → 0xFFFF80FF.
- With MISALIGN_EN, store word 0x11223344 @0x21 → four byte beats @0x21..0x24, `rsp_valid` in cycle 5. Load word @0x21 → 2 beats, 0x11223344 in cycle 3.
- Without MISALIGN_EN, LH @0x03 → `rsp_err`=1 in cycle 1, no `mem_write`.
- `req_size`=11 → `rsp_err`=1, no memory write.
- Reset asserted during beat 2 of a split store → IDLE next cycle, no further writes, no `rsp_valid`.

Source files
------------

// File: rtl/dmem_lsu.sv
// Load/store sequencer: turns one core request into registered data-memory beats.
// Define DMEM_LSU_MISALIGN_EN to split misaligned accesses; otherwise they are rejected.
module dmem_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [1:0]        mem_write,
  output logic [2:0]        mem_size_load,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef struct packed {
    logic [1:0]        wr;
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } beat_t;

  state_t            state, state_nxt;
  beat_t             cmd_nxt;
  logic              acc_err;
  logic              err_q, we_q, uns_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       buf0;

`ifdef DMEM_LSU_MISALIGN_EN
  localparam bit MISALIGN_EN = 1'b1;
  logic [31:0] buf1;
  logic [1:0]  beat, last_beat;
`else
  localparam bit MISALIGN_EN = 1'b0;
  localparam logic [1:0] beat = 2'd0;
  localparam logic [1:0] last_beat = 2'd0;
`endif

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == 2'b01) && off[0]) || ((size == 2'b10) && (off != 2'd0));
  endfunction

`ifdef DMEM_LSU_MISALIGN_EN
  // Index of the final beat: split stores go byte by byte, loads only split on a word crossing.
  function automatic logic [1:0] last_idx(input logic we, input logic [1:0] size,
                                          input logic [1:0] off);
    if (!misaligned(size, off)) return 2'd0;
    if (we) return (size == 2'b10) ? 2'd3 : 2'd1;
    return ((size == 2'b10) || (off == 2'd3)) ? 2'd1 : 2'd0;
  endfunction
`endif

  function automatic beat_t beat_cmd(input logic we, input logic [1:0] size,
                                     input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                                     input logic [1:0] k);
    beat_t             c;
    logic [ADDR_W-1:0] ak;
    c  = '0;
    ak = a + ADDR_W'(k);
    if (!we) begin
      c.a = {a[ADDR_W-1:2], 2'b00} + ADDR_W'({k, 2'b00});
    end else if (misaligned(size, a[1:0])) begin
      c.wr = 2'b11;
      c.a  = ak;
      c.d  = ((wd >> {k, 3'b000}) & 32'h0000_00FF) << {ak[1:0], 3'b000};
    end else begin
      c.a = a;
      case (size)
        2'b10:   begin c.wr = 2'b01; c.d = wd;                end
        2'b01:   begin c.wr = 2'b10; c.d = {2{wd[15:0]}};     end
        default: begin c.wr = 2'b11; c.d = {4{wd[7:0]}};      end
      endcase
    end
    return c;
  endfunction

  function automatic logic [31:0] load_ext(input logic [63:0] pair, input logic [1:0] off,
                                           input logic [1:0] size, input logic uns);
    logic [31:0]        w;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    w = 32'(pair >> {off, 3'b000});
    b = w[7:0];
    h = w[15:0];
    case (size)
      2'b00:   return uns ? {24'd0, w[7:0]}  : 32'(b);
      2'b01:   return uns ? {16'd0, w[15:0]} : 32'(h);
      default: return w;
    endcase
  endfunction

  assign acc_err = (req_size == 2'b11) ||
                   (!MISALIGN_EN && misaligned(req_size, req_addr[1:0]));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = acc_err ? RESP : BUSY;
      BUSY:    if (beat == last_beat) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_nxt = '0;
    if (state == IDLE) cmd_nxt = beat_cmd(req_we, req_size, req_addr, req_wdata, 2'd0);
    else               cmd_nxt = beat_cmd(we_q, size_q, addr_q, wdata_q, beat + 2'd1);
  end

  // Control and memory command registers; mem_* drop to zero whenever no beat is issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      err_q     <= 1'b0;
      mem_write <= 2'b00;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef DMEM_LSU_MISALIGN_EN
      beat      <= 2'd0;
      last_beat <= 2'd0;
`endif
    end else begin
      state     <= state_nxt;
      mem_write <= 2'b00;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if (state == IDLE && req_valid) begin
        err_q <= acc_err;
`ifdef DMEM_LSU_MISALIGN_EN
        beat      <= 2'd0;
        last_beat <= last_idx(req_we, req_size, req_addr[1:0]);
`endif
        if (!acc_err) begin
          mem_write <= cmd_nxt.wr;
          mem_addr  <= cmd_nxt.a;
          mem_wdata <= cmd_nxt.d;
        end
      end else if (state == BUSY && beat != last_beat) begin
`ifdef DMEM_LSU_MISALIGN_EN
        beat <= beat + 2'd1;
`endif
        mem_write <= cmd_nxt.wr;
        mem_addr  <= cmd_nxt.a;
        mem_wdata <= cmd_nxt.d;
      end
    end
  end

  // Request fields and load buffers carry data only, so they are not reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      size_q  <= req_size;
      we_q    <= req_we;
      uns_q   <= req_unsigned;
    end
    if (state == BUSY && !we_q) begin
`ifdef DMEM_LSU_MISALIGN_EN
      if (beat == 2'd0) buf0 <= mem_rdata;
      else              buf1 <= mem_rdata;
`else
      buf0 <= mem_rdata;
`endif
    end
  end

  assign req_ready     = (state == IDLE);
  assign rsp_valid     = (state == RESP);
  assign rsp_err       = (state == RESP) && err_q;
  assign mem_size_load = 3'b000;

`ifdef DMEM_LSU_MISALIGN_EN
  assign rsp_rdata = (state == RESP && !err_q && !we_q) ?
                     load_ext({buf1, buf0}, addr_q[1:0], size_q, uns_q) : 32'd0;
`else
  assign rsp_rdata = (state == RESP && !err_q && !we_q) ?
                     load_ext({32'd0, buf0}, addr_q[1:0], size_q, uns_q) : 32'd0;
`endif

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed testbench for dmem_lsu with a small byte-lane memory attached.
// Follows DMEM_LSU_MISALIGN_EN to pick the misalignment scenarios.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  mem_write;
  logic [2:0]  mem_size_load;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] tmem [0:63];

  int total = 0;
  int bad   = 0;

  int          r_cycle, n_wr;
  logic [31:0] r_data;
  logic        r_err;
  logic [31:0] wr_addr [0:7];
  logic [1:0]  wr_code [0:7];
  int          wr_cyc  [0:7];

  dmem_lsu #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_write(mem_write), .mem_size_load(mem_size_load), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] wr,
                                        input logic [1:0] a, input logic [31:0] d);
    logic [31:0] m;
    case (wr)
      2'b01:   m = 32'hFFFF_FFFF;
      2'b10:   m = a[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      2'b11:   m = 32'h0000_00FF << {a, 3'b000};
      default: m = 32'h0;
    endcase
    return (old & ~m) | (d & m);
  endfunction

  assign mem_rdata = tmem[mem_addr[7:2]];

  always @(posedge clk)
    if (mem_write != 2'b00)
      tmem[mem_addr[7:2]] <= merge(tmem[mem_addr[7:2]], mem_write, mem_addr[1:0], mem_wdata);

  // Issue one request at the next edge and log beats and the response (cycle 1 = after accept).
  task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    r_cycle = -1; n_wr = 0; r_data = 32'hX; r_err = 1'bX;
    for (int c = 1; c <= 10; c++) begin
      if (mem_write != 2'b00 && n_wr < 8) begin
        wr_addr[n_wr] = mem_addr; wr_code[n_wr] = mem_write; wr_cyc[n_wr] = c;
        n_wr++;
      end
      if (rsp_valid) begin
        r_cycle = c; r_data = rsp_rdata; r_err = rsp_err;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
    req_unsigned = 1'b0; req_addr = 32'h10; req_wdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
      total++; if (mem_write !== 2'b00) begin bad++; $display("FAIL reset_mem_write got=%b exp=00", mem_write); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    end
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
    total++; if (mem_size_load !== 3'b000) begin bad++; $display("FAIL reset_size_load got=%b exp=000", mem_size_load); end
    req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word();
    run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    total++; if (n_wr !== 1) begin bad++; $display("FAIL sw_beats got=%0d exp=1", n_wr); end
    total++; if (wr_code[0] !== 2'b01 || wr_cyc[0] !== 1) begin bad++; $display("FAIL sw_write got=%b@%0d exp=01@1", wr_code[0], wr_cyc[0]); end
    total++; if (wr_addr[0] !== 32'h10) begin bad++; $display("FAIL sw_addr got=%h exp=00000010", wr_addr[0]); end
    total++; if (r_cycle !== 2) begin bad++; $display("FAIL sw_rsp_cycle got=%0d exp=2", r_cycle); end
    total++; if (r_data !== 32'h0 || r_err !== 1'b0) begin bad++; $display("FAIL sw_rsp got=%h/%b exp=0/0", r_data, r_err); end
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    total++; if (r_cycle !== 2) begin bad++; $display("FAIL lw_rsp_cycle got=%0d exp=2", r_cycle); end
    total++; if (r_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_data got=%h exp=deadbeef", r_data); end
    total++; if (n_wr !== 0) begin bad++; $display("FAIL lw_no_write got=%0d exp=0", n_wr); end
  endtask

  task automatic test_extend();
    run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF_7F01);
    run_req(1'b0, 2'b00, 1'b0, 32'h12, 32'h0);
    total++; if (r_data !== 32'hFFFF_FFFF) begin bad++; $display("FAIL lb_12 got=%h exp=ffffffff", r_data); end
    run_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    total++; if (r_data !== 32'h0000_0080) begin bad++; $display("FAIL lbu_13 got=%h exp=00000080", r_data); end
    run_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    total++; if (r_data !== 32'hFFFF_80FF) begin bad++; $display("FAIL lh_12 got=%h exp=ffff80ff", r_data); end
    run_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
    total++; if (r_data !== 32'h0000_7F01) begin bad++; $display("FAIL lhu_10 got=%h exp=00007f01", r_data); end
    run_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    total++; if (r_data !== 32'h0000_007F) begin bad++; $display("FAIL lb_11 got=%h exp=0000007f", r_data); end
    run_req(1'b0, 2'b10, 1'b1, 32'h10, 32'h0);
    total++; if (r_data !== 32'h80FF_7F01) begin bad++; $display("FAIL lw_unsigned got=%h exp=80ff7f01", r_data); end
  endtask

  task automatic test_subword_store();
    run_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h1234_56AB);
    total++; if (wr_code[0] !== 2'b11 || wr_addr[0] !== 32'h11) begin bad++; $display("FAIL sb_beat got=%b@%h exp=11@00000011", wr_code[0], wr_addr[0]); end
    run_req(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF_1234);
    total++; if (wr_code[0] !== 2'b10 || wr_addr[0] !== 32'h12) begin bad++; $display("FAIL sh_beat got=%b@%h exp=10@00000012", wr_code[0], wr_addr[0]); end
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    total++; if (r_data !== 32'h1234_AB01) begin bad++; $display("FAIL sub_store_word got=%h exp=1234ab01", r_data); end
  endtask

  task automatic test_illegal();
    run_req(1'b1, 2'b11, 1'b0, 32'h30, 32'hCAFE_F00D);
    total++; if (r_cycle !== 1) begin bad++; $display("FAIL ill_cycle got=%0d exp=1", r_cycle); end
    total++; if (r_err !== 1'b1 || r_data !== 32'h0) begin bad++; $display("FAIL ill_rsp got=%b/%h exp=1/0", r_err, r_data); end
    total++; if (n_wr !== 0) begin bad++; $display("FAIL ill_no_write got=%0d exp=0", n_wr); end
    total++; if (tmem[12] !== 32'h0) begin bad++; $display("FAIL ill_mem got=%h exp=0", tmem[12]); end
    run_req(1'b0, 2'b00, 1'b0, 32'h12, 32'h0);
    total++; if (r_cycle !== 2 || r_err !== 1'b0) begin bad++; $display("FAIL after_ill got=%0d/%b exp=2/0", r_cycle, r_err); end
  endtask

  task automatic test_misalign();
`ifdef DMEM_LSU_MISALIGN_EN
    run_req(1'b1, 2'b10, 1'b0, 32'h21, 32'h1122_3344);
    total++; if (n_wr !== 4) begin bad++; $display("FAIL msw_beats got=%0d exp=4", n_wr); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (wr_addr[i] !== 32'h21 + i || wr_code[i] !== 2'b11) begin
        bad++; $display("FAIL msw_beat%0d got=%b@%h exp=11@%h", i, wr_code[i], wr_addr[i], 32'h21 + i);
      end
    end
    total++; if (r_cycle !== 5) begin bad++; $display("FAIL msw_rsp_cycle got=%0d exp=5", r_cycle); end
    run_req(1'b0, 2'b10, 1'b0, 32'h21, 32'h0);
    total++; if (r_cycle !== 3) begin bad++; $display("FAIL mlw_cycle got=%0d exp=3", r_cycle); end
    total++; if (r_data !== 32'h1122_3344) begin bad++; $display("FAIL mlw_data got=%h exp=11223344", r_data); end
    run_req(1'b0, 2'b01, 1'b0, 32'h23, 32'h0);
    total++; if (r_cycle !== 3 || r_data !== 32'h0000_1122) begin bad++; $display("FAIL mlh_23 got=%h@%0d exp=00001122@3", r_data, r_cycle); end
    run_req(1'b0, 2'b01, 1'b0, 32'h21, 32'h0);
    total++; if (r_cycle !== 2 || r_data !== 32'h0000_3344) begin bad++; $display("FAIL mlh_21 got=%h@%0d exp=00003344@2", r_data, r_cycle); end
`else
    run_req(1'b0, 2'b01, 1'b0, 32'h03, 32'h0);
    total++; if (r_cycle !== 1) begin bad++; $display("FAIL mlh_cycle got=%0d exp=1", r_cycle); end
    total++; if (r_err !== 1'b1 || r_data !== 32'h0) begin bad++; $display("FAIL mlh_rsp got=%b/%h exp=1/0", r_err, r_data); end
    total++; if (n_wr !== 0) begin bad++; $display("FAIL mlh_no_beat got=%0d exp=0", n_wr); end
    run_req(1'b1, 2'b10, 1'b0, 32'h22, 32'h5555_AAAA);
    total++; if (r_cycle !== 1 || r_err !== 1'b1) begin bad++; $display("FAIL msw_err got=%0d/%b exp=1/1", r_cycle, r_err); end
    total++; if (n_wr !== 0 || tmem[8] !== 32'h0) begin bad++; $display("FAIL msw_no_write got=%0d/%h exp=0/0", n_wr, tmem[8]); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, wd, exp_w;
    logic [1:0]  sz;
    int          n_before;
`ifdef DMEM_LSU_MISALIGN_EN
    a = 32'h41; sz = 2'b10; wd = 32'hAABB_CCDD; exp_w = 32'h00CC_DD00; n_before = 3;
`else
    a = 32'h50; sz = 2'b00; wd = 32'h0000_0055; exp_w = 32'h0; n_before = 1;
`endif
    req_valid = 1'b1; req_we = 1'b1; req_size = sz; req_unsigned = 1'b0;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    for (int c = 1; c <= n_before; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    total++; if (mem_write !== 2'b11) begin bad++; $display("FAIL mid_beat got=%b exp=11", mem_write); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (req_ready !== 1'b1 || mem_write !== 2'b00) begin bad++; $display("FAIL mid_idle got=%b/%b exp=1/00", req_ready, mem_write); end
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0 || mem_write !== 2'b00) begin
        bad++; $display("FAIL mid_quiet%0d got=%b/%b exp=0/00", c, rsp_valid, mem_write);
      end
    end
    total++; if (tmem[a[7:2]] !== exp_w) begin bad++; $display("FAIL mid_mem got=%h exp=%h", tmem[a[7:2]], exp_w); end
    total++; if (tmem[a[7:2] + 1] !== 32'h0) begin bad++; $display("FAIL mid_mem_next got=%h exp=0", tmem[a[7:2] + 1]); end
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    total++; if (r_cycle !== 2 || r_data !== 32'h1234_AB01) begin bad++; $display("FAIL mid_recover got=%h@%0d exp=1234ab01@2", r_data, r_cycle); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) tmem[i] = 32'h0;
    test_reset();
    test_word();
    test_extend();
    test_subword_store();
    test_illegal();
    test_misalign();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
